// File: rtl/crotchet_sequencer.sv
// Musical timebase for the canon demo.
// Divides clk into semiquaver ticks, counts semiquavers into crotchets and
// exposes the crotchet index plus single-cycle tick strobes. Every output is a
// register, so each tick lands in the same cycle as the count it announces.
module crotchet_sequencer #(
  parameter int SEMI_CYCLES   = 5454545,
  parameter int NUM_CROTCHETS = 104,
  parameter int LOOP_TO       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       restart,
  input  logic       skip_phrase,
  output logic [6:0] crotchet,
  output logic [1:0] sub_beat,
  output logic       semi_tick,
  output logic       crotchet_tick,
  output logic       phrase_tick,
  output logic       loop_tick
);

  localparam int PW = $clog2(SEMI_CYCLES);
  localparam logic [PW-1:0] PRESC_TERM = PW'(SEMI_CYCLES - 1);
  localparam logic [6:0]    LAST_CROT  = 7'(NUM_CROTCHETS - 1);
  localparam logic [6:0]    LOOP_CROT  = 7'(LOOP_TO);
  localparam logic [7:0]    NUM_CROT8  = 8'(NUM_CROTCHETS);

  logic [PW-1:0] r_presc;
  logic [6:0]    r_crotchet;
  logic [1:0]    r_sub_beat;
  logic          r_semi_tick;
  logic          r_crotchet_tick;
  logic          r_phrase_tick;
  logic          r_loop_tick;

  logic [PW-1:0] w_presc_next;
  logic [6:0]    w_crotchet_next;
  logic [1:0]    w_sub_beat_next;
  logic          w_semi_tick_next;
  logic          w_crotchet_tick_next;
  logic          w_phrase_tick_next;
  logic          w_loop_tick_next;

  // Skip target is formed in 8 bits so that 120|7 + 1 = 128 does not wrap to 0.
  logic [7:0]    w_skip_target;
  logic          w_skip_wraps;
  logic          w_presc_term;
  logic          w_last_crot;

  assign w_skip_target = ({1'b0, r_crotchet} | 8'd7) + 8'd1;
  assign w_skip_wraps  = (w_skip_target >= NUM_CROT8);
  assign w_presc_term  = (r_presc == PRESC_TERM);
  assign w_last_crot   = (r_crotchet == LAST_CROT);

  // Next-state selection: restart beats skip, skip beats normal advance.
  always_comb begin
    w_presc_next         = r_presc;
    w_crotchet_next      = r_crotchet;
    w_sub_beat_next      = r_sub_beat;
    w_semi_tick_next     = 1'b0;
    w_crotchet_tick_next = 1'b0;
    w_phrase_tick_next   = 1'b0;
    w_loop_tick_next     = 1'b0;

    if (restart) begin
      w_presc_next    = '0;
      w_sub_beat_next = 2'd0;
      w_crotchet_next = 7'd0;
    end else if (skip_phrase) begin
      // Any coincident terminal count is dropped: one crotchet change only.
      w_presc_next         = '0;
      w_sub_beat_next      = 2'd0;
      w_crotchet_tick_next = 1'b1;
      w_phrase_tick_next   = 1'b1;
      if (w_skip_wraps) begin
        w_crotchet_next  = LOOP_CROT;
        w_loop_tick_next = 1'b1;
      end else begin
        w_crotchet_next  = w_skip_target[6:0];
      end
    end else if (run) begin
      if (!w_presc_term) begin
        w_presc_next = r_presc + 1'b1;
      end else begin
        w_presc_next     = '0;
        w_sub_beat_next  = r_sub_beat + 2'd1;
        w_semi_tick_next = 1'b1;
        if (r_sub_beat == 2'd3) begin
          w_crotchet_tick_next = 1'b1;
          if (w_last_crot) begin
            w_crotchet_next  = LOOP_CROT;
            w_loop_tick_next = 1'b1;
          end else begin
            w_crotchet_next  = r_crotchet + 7'd1;
          end
          w_phrase_tick_next = (w_crotchet_next[2:0] == 3'd0);
        end
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_presc         <= '0;
      r_crotchet      <= 7'd0;
      r_sub_beat      <= 2'd0;
      r_semi_tick     <= 1'b0;
      r_crotchet_tick <= 1'b0;
      r_phrase_tick   <= 1'b0;
      r_loop_tick     <= 1'b0;
    end else begin
      r_presc         <= w_presc_next;
      r_crotchet      <= w_crotchet_next;
      r_sub_beat      <= w_sub_beat_next;
      r_semi_tick     <= w_semi_tick_next;
      r_crotchet_tick <= w_crotchet_tick_next;
      r_phrase_tick   <= w_phrase_tick_next;
      r_loop_tick     <= w_loop_tick_next;
    end
  end

  assign crotchet      = r_crotchet;
  assign sub_beat      = r_sub_beat;
  assign semi_tick     = r_semi_tick;
  assign crotchet_tick = r_crotchet_tick;
  assign phrase_tick   = r_phrase_tick;
  assign loop_tick     = r_loop_tick;

endmodule

// File: tb/tb_crotchet_sequencer.sv
// Directed bench for crotchet_sequencer with SEMI_CYCLES=4, 24 crotchets, loop to 8.
module tb_crotchet_sequencer;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic       restart;
  logic       skip_phrase;
  logic [6:0] crotchet;
  logic [1:0] sub_beat;
  logic       semi_tick;
  logic       crotchet_tick;
  logic       phrase_tick;
  logic       loop_tick;

  int errors = 0;
  int checks = 0;

  crotchet_sequencer #(
    .SEMI_CYCLES  (4),
    .NUM_CROTCHETS(24),
    .LOOP_TO      (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .restart      (restart),
    .skip_phrase  (skip_phrase),
    .crotchet     (crotchet),
    .sub_beat     (sub_beat),
    .semi_tick    (semi_tick),
    .crotchet_tick(crotchet_tick),
    .phrase_tick  (phrase_tick),
    .loop_tick    (loop_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed outputs packed as {crotchet, sub_beat, semi, crot, phrase, loop}.
  logic [12:0] obs;
  assign obs = {crotchet, sub_beat, semi_tick, crotchet_tick, phrase_tick, loop_tick};

  // Closed-form expectation after n running clock edges following reset release.
  function automatic logic [12:0] model(input int n);
    int semi, clin, crot;
    logic st, ct, pt, lt;
    semi = n / 4;
    clin = semi / 4;
    crot = (clin < 24) ? clin : 8 + ((clin - 24) % 16);
    st   = (n > 0) && (n % 4 == 0);
    ct   = (n > 0) && (n % 16 == 0);
    pt   = ct && (crot % 8 == 0);
    lt   = ct && (clin >= 24) && ((clin - 24) % 16 == 0);
    return {7'(crot), 2'(semi % 4), st, ct, pt, lt};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic advance(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; run = 1'b0; restart = 1'b0; skip_phrase = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b1; restart = 1'b0; skip_phrase = 1'b0;
    for (int i = 0; i < 3; i++) begin
      skip_phrase = (i == 1);
      step();
      checks++;
      if (obs !== 13'd0) begin
        errors++;
        $display("FAIL reset_zero cycle %0d: got %h expected %h", i, obs, 13'd0);
      end
    end
    skip_phrase = 1'b0;
    $display("reset: held 3 cycles");
  endtask

  task automatic test_count_and_wrap();
    logic [12:0] e;
    rst_n = 1'b1; run = 1'b1;
    for (int n = 1; n <= 700; n++) begin
      step();
      e = model(n);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL count n=%0d: got %h expected %h", n, obs, e);
      end
      if (n == 384) begin
        checks++;
        if (obs !== {7'd8, 2'd0, 4'b1111}) begin
          errors++;
          $display("FAIL loop_wrap: got %h expected %h", obs, {7'd8, 2'd0, 4'b1111});
        end
      end
      if (n > 384) begin
        checks++;
        if (crotchet < 7'd8) begin
          errors++;
          $display("FAIL no_revisit n=%0d: got crotchet %0d expected >=8", n, crotchet);
        end
      end
      if (crotchet_tick) $display("count: n=%0d crotchet=%0d loop=%0b", n, crotchet, loop_tick);
    end
  endtask

  task automatic test_pause();
    do_reset();
    run = 1'b1;
    advance(38);
    checks++;
    if (obs !== {7'd2, 2'd1, 4'b0000}) begin
      errors++;
      $display("FAIL pause_setup: got %h expected %h", obs, {7'd2, 2'd1, 4'b0000});
    end
    run = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      checks++;
      if (obs !== {7'd2, 2'd1, 4'b0000}) begin
        errors++;
        $display("FAIL pause_frozen cycle %0d: got %h expected %h", i, obs, {7'd2, 2'd1, 4'b0000});
      end
    end
    run = 1'b1;
    step();
    checks++;
    if (obs !== {7'd2, 2'd1, 4'b0000}) begin
      errors++;
      $display("FAIL resume_1: got %h expected %h", obs, {7'd2, 2'd1, 4'b0000});
    end
    step();
    checks++;
    if (obs !== {7'd2, 2'd2, 4'b1000}) begin
      errors++;
      $display("FAIL resume_2: got %h expected %h", obs, {7'd2, 2'd2, 4'b1000});
    end
    $display("pause: 100 frozen cycles, resumed at crotchet=%0d sub=%0d", crotchet, sub_beat);
  endtask

  task automatic test_skip();
    do_reset();
    run = 1'b1;
    advance(88);
    checks++;
    if (obs !== {7'd5, 2'd2, 4'b1000}) begin
      errors++;
      $display("FAIL skip_setup: got %h expected %h", obs, {7'd5, 2'd2, 4'b1000});
    end
    skip_phrase = 1'b1; step(); skip_phrase = 1'b0;
    checks++;
    if (obs !== {7'd8, 2'd0, 4'b0110}) begin
      errors++;
      $display("FAIL skip_5_to_8: got %h expected %h", obs, {7'd8, 2'd0, 4'b0110});
    end
    $display("skip: 5 -> %0d", crotchet);
    advance(3);
    checks++;
    if (obs !== {7'd8, 2'd0, 4'b0000}) begin
      errors++;
      $display("FAIL skip_phase_early: got %h expected %h", obs, {7'd8, 2'd0, 4'b0000});
    end
    step();
    checks++;
    if (obs !== {7'd8, 2'd1, 4'b1000}) begin
      errors++;
      $display("FAIL skip_phase_tick: got %h expected %h", obs, {7'd8, 2'd1, 4'b1000});
    end
    skip_phrase = 1'b1; step(); skip_phrase = 1'b0;
    checks++;
    if (obs !== {7'd16, 2'd0, 4'b0110}) begin
      errors++;
      $display("FAIL skip_8_to_16: got %h expected %h", obs, {7'd16, 2'd0, 4'b0110});
    end
    advance(48);
    checks++;
    if (obs !== {7'd19, 2'd0, 4'b1100}) begin
      errors++;
      $display("FAIL skip_setup19: got %h expected %h", obs, {7'd19, 2'd0, 4'b1100});
    end
    skip_phrase = 1'b1; step(); skip_phrase = 1'b0;
    checks++;
    if (obs !== {7'd8, 2'd0, 4'b0111}) begin
      errors++;
      $display("FAIL skip_19_wrap: got %h expected %h", obs, {7'd8, 2'd0, 4'b0111});
    end
    $display("skip: 19 -> %0d loop=%0b", crotchet, loop_tick);
    run = 1'b0;
    skip_phrase = 1'b1; step(); skip_phrase = 1'b0;
    checks++;
    if (obs !== {7'd16, 2'd0, 4'b0110}) begin
      errors++;
      $display("FAIL skip_paused: got %h expected %h", obs, {7'd16, 2'd0, 4'b0110});
    end
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (obs !== {7'd16, 2'd0, 4'b0000}) begin
        errors++;
        $display("FAIL skip_paused_hold cycle %0d: got %h expected %h", i, obs, {7'd16, 2'd0, 4'b0000});
      end
    end
    $display("skip: paused jump to %0d, held", crotchet);
    run = 1'b1;
    advance(15);
    checks++;
    if (obs !== {7'd16, 2'd3, 4'b0000}) begin
      errors++;
      $display("FAIL skip_term_setup: got %h expected %h", obs, {7'd16, 2'd3, 4'b0000});
    end
    skip_phrase = 1'b1; step(); skip_phrase = 1'b0;
    checks++;
    if (obs !== {7'd8, 2'd0, 4'b0111}) begin
      errors++;
      $display("FAIL skip_at_terminal: got %h expected %h", obs, {7'd8, 2'd0, 4'b0111});
    end
    advance(3);
    checks++;
    if (obs !== {7'd8, 2'd0, 4'b0000}) begin
      errors++;
      $display("FAIL skip_term_after: got %h expected %h", obs, {7'd8, 2'd0, 4'b0000});
    end
    $display("skip: at terminal count -> %0d", crotchet);
  endtask

  task automatic test_restart();
    do_reset();
    run = 1'b1;
    advance(211);
    checks++;
    if (obs !== {7'd13, 2'd0, 4'b0000}) begin
      errors++;
      $display("FAIL restart_setup: got %h expected %h", obs, {7'd13, 2'd0, 4'b0000});
    end
    restart = 1'b1; skip_phrase = 1'b1; step(); restart = 1'b0; skip_phrase = 1'b0;
    checks++;
    if (obs !== 13'd0) begin
      errors++;
      $display("FAIL restart_clear: got %h expected %h", obs, 13'd0);
    end
    advance(3);
    checks++;
    if (obs !== 13'd0) begin
      errors++;
      $display("FAIL restart_early: got %h expected %h", obs, 13'd0);
    end
    step();
    checks++;
    if (obs !== {7'd0, 2'd1, 4'b1000}) begin
      errors++;
      $display("FAIL restart_first_tick: got %h expected %h", obs, {7'd0, 2'd1, 4'b1000});
    end
    $display("restart: from crotchet 13 with skip and terminal count");
  endtask

  task automatic test_mid_reset();
    logic [12:0] e;
    do_reset();
    run = 1'b1;
    advance(166);
    checks++;
    if (obs !== {7'd10, 2'd1, 4'b0000}) begin
      errors++;
      $display("FAIL midreset_setup: got %h expected %h", obs, {7'd10, 2'd1, 4'b0000});
    end
    rst_n = 1'b0; step(); rst_n = 1'b1;
    checks++;
    if (obs !== 13'd0) begin
      errors++;
      $display("FAIL midreset_zero: got %h expected %h", obs, 13'd0);
    end
    for (int n = 1; n <= 20; n++) begin
      step();
      e = model(n);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL midreset_count n=%0d: got %h expected %h", n, obs, e);
      end
    end
    $display("mid_reset: recount to crotchet=%0d sub=%0d", crotchet, sub_beat);
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; restart = 1'b0; skip_phrase = 1'b0;
    test_reset();
    test_count_and_wrap();
    test_pause();
    test_skip();
    test_restart();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
